// File: rtl/wave_player_pkg.sv
// Shared constants for the multichannel wave player: CSR map, CTRL/STATUS bit
// positions and the fetch state encoding.
package wave_player_pkg;

  localparam logic [1:0] CSR_LENGTH = 2'd0;
  localparam logic [1:0] CSR_BASE   = 2'd1;
  localparam logic [1:0] CSR_CTRL   = 2'd2;
  localparam logic [1:0] CSR_STATUS = 2'd3;

  localparam int CTRL_START        = 0;
  localparam int CTRL_LOOP         = 1;
  localparam int STAT_BUSY         = 0;
  localparam int STAT_DONE         = 1;
  localparam int STAT_UNDERRUN_LSB = 16;
  localparam int UNDERRUN_W        = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_PUSH,
    ST_DRAIN
  } fetch_state_t;

endpackage

// File: rtl/frame_fifo.sv
// Synchronous frame FIFO with flush. A write into a full FIFO is accepted when
// a read happens in the same cycle.
module frame_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W:0]   wr_ptr;
  logic [PTR_W:0]   rd_ptr;
  logic             do_wr;
  logic             do_rd;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                   (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign do_wr   = wr_en && (!full || rd_en);
  assign do_rd   = rd_en && !empty;
  assign rd_data = mem[rd_ptr[PTR_W-1:0]];

  always_ff @(posedge clock) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + (PTR_W+1)'(1);
      if (do_rd) rd_ptr <= rd_ptr + (PTR_W+1)'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (do_wr) mem[wr_ptr[PTR_W-1:0]] <= wr_data;
  end

endmodule

// File: rtl/multichannel_wave_player.sv
// Fetches interleaved multichannel frames from word memory into a prefetch FIFO
// and streams them out. Define WAVE_PLAYER_UNDERRUN_COUNT_EN to build the underrun counter.
module multichannel_wave_player
  import wave_player_pkg::*;
#(
  parameter int NUM_CH     = 2,
  parameter int SAMPLE_W   = 16,
  parameter int FIFO_DEPTH = 16,
  parameter int ADDR_W     = 26
) (
  input  logic                       audio_clock,
  input  logic                       audio_reset,
  input  logic [1:0]                 csr_address,
  input  logic                       csr_write,
  input  logic [31:0]                csr_writedata,
  input  logic                       csr_read,
  output logic [31:0]                csr_readdata,
  output logic [ADDR_W-1:0]          mem_addr,
  output logic                       mem_read,
  input  logic                       mem_waitrequest,
  input  logic [SAMPLE_W-1:0]        mem_readdata,
  input  logic                       mem_readdatavalid,
  output logic [NUM_CH*SAMPLE_W-1:0] ch_data,
  output logic [NUM_CH-1:0]          ch_valid,
  input  logic [NUM_CH-1:0]          ch_ready
);

  localparam int FRAME_W  = NUM_CH * SAMPLE_W;
  localparam int CH_IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [31:0]         len_reg;
  logic [ADDR_W-1:0]   base_reg;
  logic                ctrl_start;
  logic                ctrl_loop;
  logic [31:0]         len_q;
  logic [ADDR_W-1:0]   base_q;
  logic                loop_q;

  fetch_state_t        state;
  fetch_state_t        state_nxt;
  logic [ADDR_W-1:0]   rd_addr;
  logic [31:0]         frame_cnt;
  logic [CH_IDX_W-1:0] ch_idx;
  logic [FRAME_W-1:0]  stage;
  logic                aborting;
  logic                done;

  logic                fifo_full;
  logic                fifo_empty;
  logic                fifo_push;
  logic                fifo_pop;
  logic                fifo_flush;
  logic [FRAME_W-1:0]  fifo_rd_data;

  logic                busy;
  logic                ctrl_wr;
  logic                start_ok;
  logic                abort_now;
  logic                abort_any;
  logic                mem_accept;
  logic                last_word;
  logic                last_frame;
  logic [15:0]         underrun;
  logic [31:0]         status;
  logic [31:0]         rd_mux;

  assign busy       = (state != ST_IDLE);
  assign ctrl_wr    = csr_write && (csr_address == CSR_CTRL);
  assign start_ok   = ctrl_wr && csr_writedata[CTRL_START] && !ctrl_start &&
                      (len_reg != 32'd0) && (state == ST_IDLE);
  assign abort_now  = ctrl_wr && !csr_writedata[CTRL_START] && busy;
  assign abort_any  = abort_now || aborting;
  assign mem_accept = (state == ST_REQ) && !mem_waitrequest;
  assign last_word  = (ch_idx == CH_IDX_W'(NUM_CH - 1));
  assign last_frame = (frame_cnt + 32'd1) >= len_q;

  assign mem_read   = (state == ST_REQ);
  assign mem_addr   = rd_addr;

  // A pop frees a slot in the same cycle, so a full FIFO still takes the push.
  assign fifo_pop   = busy && !fifo_empty && !abort_any && (&ch_ready);
  assign fifo_push  = (state == ST_PUSH) && !abort_now && (!fifo_full || fifo_pop);

  always_comb begin
    state_nxt  = state;
    fifo_flush = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start_ok) state_nxt = ST_REQ;
      end
      ST_REQ: begin
        if (abort_now && mem_waitrequest) begin
          state_nxt  = ST_IDLE;
          fifo_flush = 1'b1;
        end else if (!mem_waitrequest) begin
          state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (mem_readdatavalid) begin
          if (abort_any) begin
            state_nxt  = ST_IDLE;
            fifo_flush = 1'b1;
          end else begin
            state_nxt = last_word ? ST_PUSH : ST_REQ;
          end
        end
      end
      ST_PUSH: begin
        if (abort_now) begin
          state_nxt  = ST_IDLE;
          fifo_flush = 1'b1;
        end else if (fifo_push) begin
          state_nxt = (last_frame && !loop_q) ? ST_DRAIN : ST_REQ;
        end
      end
      ST_DRAIN: begin
        if (abort_now) begin
          state_nxt  = ST_IDLE;
          fifo_flush = 1'b1;
        end else if (fifo_empty) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge audio_clock) begin
    if (audio_reset) begin
      state      <= ST_IDLE;
      len_reg    <= '0;
      base_reg   <= '0;
      ctrl_start <= 1'b0;
      ctrl_loop  <= 1'b0;
      len_q      <= '0;
      base_q     <= '0;
      loop_q     <= 1'b0;
      rd_addr    <= '0;
      frame_cnt  <= '0;
      ch_idx     <= '0;
      aborting   <= 1'b0;
      done       <= 1'b0;
    end else begin
      state <= state_nxt;
      if (csr_write) begin
        case (csr_address)
          CSR_LENGTH: len_reg  <= csr_writedata;
          CSR_BASE:   base_reg <= csr_writedata[ADDR_W-1:0];
          CSR_CTRL: begin
            ctrl_start <= csr_writedata[CTRL_START];
            ctrl_loop  <= csr_writedata[CTRL_LOOP];
          end
          default: ;
        endcase
      end
      // Playback parameters are frozen for the whole run.
      if (start_ok) begin
        len_q     <= len_reg;
        base_q    <= base_reg;
        loop_q    <= csr_writedata[CTRL_LOOP];
        rd_addr   <= base_reg;
        frame_cnt <= '0;
        ch_idx    <= '0;
        done      <= 1'b0;
      end
      if (mem_accept) rd_addr <= rd_addr + ADDR_W'(1);
      if ((state == ST_WAIT) && mem_readdatavalid && !abort_any)
        ch_idx <= last_word ? '0 : ch_idx + CH_IDX_W'(1);
      if (fifo_push) begin
        if (last_frame) begin
          frame_cnt <= '0;
          if (loop_q) rd_addr <= base_q;
        end else begin
          frame_cnt <= frame_cnt + 32'd1;
        end
      end
      if (state_nxt == ST_IDLE)
        aborting <= 1'b0;
      else if (abort_now && ((state == ST_WAIT) || mem_accept))
        aborting <= 1'b1;
      if (fifo_flush) begin
        done   <= 1'b0;
        ch_idx <= '0;
      end else if ((state == ST_DRAIN) && (state_nxt == ST_IDLE)) begin
        done <= 1'b1;
      end
    end
  end

  always_ff @(posedge audio_clock) begin
    if ((state == ST_WAIT) && mem_readdatavalid) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (ch_idx == CH_IDX_W'(c)) stage[c*SAMPLE_W +: SAMPLE_W] <= mem_readdata;
      end
    end
  end

  frame_fifo #(
    .WIDTH (FRAME_W),
    .DEPTH (FIFO_DEPTH)
  ) u_frame_fifo (
    .clock   (audio_clock),
    .reset   (audio_reset),
    .flush   (fifo_flush),
    .wr_en   (fifo_push),
    .wr_data (stage),
    .rd_en   (fifo_pop),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // output stage: one-cycle valid pulse per popped frame
  always_ff @(posedge audio_clock) begin
    if (audio_reset) begin
      ch_valid <= '0;
      ch_data  <= '0;
    end else begin
      ch_valid <= {NUM_CH{fifo_pop}};
      if (fifo_pop) ch_data <= fifo_rd_data;
    end
  end

`ifdef WAVE_PLAYER_UNDERRUN_COUNT_EN
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge audio_clock) begin
    if (audio_reset)
      underrun <= '0;
    else if (busy && (&ch_ready) && fifo_empty && (state != ST_DRAIN))
      underrun <= sat_inc16(underrun);
  end
`else
  assign underrun = '0;
`endif

  always_comb begin
    status = '0;
    status[STAT_BUSY] = busy;
    status[STAT_DONE] = done;
    status[STAT_UNDERRUN_LSB +: UNDERRUN_W] = underrun;
  end

  always_comb begin
    rd_mux = '0;
    case (csr_address)
      CSR_LENGTH: rd_mux = len_reg;
      CSR_BASE:   rd_mux = 32'(base_reg);
      CSR_CTRL:   rd_mux = {30'd0, ctrl_loop, ctrl_start};
      CSR_STATUS: rd_mux = status;
      default:    rd_mux = '0;
    endcase
  end

  always_ff @(posedge audio_clock) begin
    if (audio_reset)
      csr_readdata <= '0;
    else if (csr_read)
      csr_readdata <= rd_mux;
  end

endmodule
